// File: rtl/seq_pattern_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector
// Description : Parametrised Mealy serial-pattern detector with a loadable
//               pattern, overlap control, optional sticky flag and a
//               saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector #(
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1101,
    parameter bit                 OVERLAP  = 1'b1,
    parameter bit                 STICKY   = 1'b0,
    parameter int                 CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din,
    input  logic               pat_wr,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               clear,
    output logic               match,
    output logic               match_q,
    output logic               found,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam int                FILL_W     = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

    logic [PAT_LEN-1:0] r_pattern;
    logic [PAT_LEN-2:0] r_history;
    logic [FILL_W-1:0]  r_fill;
    logic               r_match_q;
    logic [CNT_W-1:0]   r_count;
    logic               r_count_sat;

    logic [PAT_LEN-1:0] w_window;
    logic               w_full;
    logic               w_match;
    logic               w_restart;
    logic [CNT_W-1:0]   w_count_next;

    // The window is the stored history with the incoming bit appended as LSB.
    assign w_window  = {r_history, din};
    assign w_full    = (r_fill == c_FILL_MAX);
    assign w_match   = din_valid & ~clear & ~pat_wr & w_full & (w_window == r_pattern);
    assign w_restart = clear | pat_wr | (w_match & (OVERLAP == 1'b0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern <= PAT_INIT;
        end else if (pat_wr) begin
            r_pattern <= pat_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_history <= '0;
            r_fill    <= '0;
        end else if (w_restart) begin
            r_history <= '0;
            r_fill    <= '0;
        end else if (din_valid) begin
            r_history <= w_window[PAT_LEN-2:0];
            if (!w_full) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    // Clear already forces w_match low, so match_q drops with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (w_match && (r_count != c_CNT_MAX)) begin
            w_count_next = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_count_sat <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_count_sat <= &w_count_next;
        end
    end

    if (STICKY) begin : g_sticky
        logic r_found;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_found <= 1'b0;
            end else if (clear) begin
                r_found <= 1'b0;
            end else if (w_match) begin
                r_found <= 1'b1;
            end
        end
        assign found = r_found;
    end else begin : g_mirror
        assign found = r_match_q;
    end

    assign match       = w_match;
    assign match_q     = r_match_q;
    assign match_count = r_count;
    assign count_sat   = r_count_sat;

endmodule
`default_nettype wire
